mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle successor to the single-cycle main decoder: a Moore/Mealy FSM that sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK for the MIPS subset (R-type, lw, sw, beq, bne, addi, andi, ori, slti, lui, j, jal, optional jr).
- Sits between the instruction register and the shared datapath (PC, unified memory, register file, ALU).
- Adds a memory-ready handshake, a bounded-wait watchdog, 2-bit RegDst/MemtoReg so jal can write $ra, and a per-instruction retire pulse.

Parameters:
OP_W, 6, opcode width (instr[31:26])
FN_W, 6, funct width (instr[5:0])
MEM_WAIT_MAX, 0, max cycles waiting on mem_ready before abort; 0 disables the watchdog
WAIT_CNT_W, 8, watchdog counter width; requires MEM_WAIT_MAX < 2**WAIT_CNT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OP_W  IR opcode field, stable from DECODE until retire
funct  in  FN_W  IR funct field
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition holds
branch_ne  out  1  condition is !Zero (bne) instead of Zero
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr)
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct, 11 opcode
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal_op  out  1  one-cycle pulse, unsupported opcode seen in DECODE
mem_timeout  out  1  one-cycle pulse, watchdog abort
state_o  out  4  current state encoding, debug only

Behaviour:
- Reset: state register = FETCH and all outputs are 0 while rst_n is low. Reset is honoured in any state and drops any in-flight access. The first cycle after release is FETCH.
- Outputs are decoded from state. Exceptions (Mealy): ir_write, pc_write and the advancing transition in FETCH/MEMRD/MEMWR, which qualify on mem_ready.
- Unlisted outputs are 0 in each state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. On mem_ready: ir_write=1, pc_write=1, pc_source=00, go to DECODE. Otherwise stay.
- DECODE: alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 0 -> EXEC
  - 35, 43 -> MEMADR
  - 4, 5 -> BRANCH
  - 8 -> IEXEC (alu_op=00)
  - 10, 12, 13, 15 -> IEXEC (alu_op=11)
  - 2 -> JUMP
  - 3 -> JAL
  - other -> FETCH with illegal_op=1 (no instr_done)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD (35) or MEMWR (43).
- MEMRD: mem_read=1, iord=1. On mem_ready go to MEMWB.
- MEMWB: reg_dst=00, mem_to_reg=01, reg_write=1, instr_done=1, go to FETCH.
- MEMWR: mem_write=1, iord=1. On mem_ready: instr_done=1, go to FETCH.
- EXEC: alu_src_a=1, alu_op=10, go to ALUWB.
- ALUWB: reg_dst=01, reg_write=1, instr_done=1, go to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==5), instr_done=1, go to FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op as latched above, go to IWB.
- IWB: reg_dst=00, mem_to_reg=00, reg_write=1, instr_done=1, go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1, go to FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1, go to FETCH. The register file captures the pre-edge PC (already PC+4).
- Watchdog (MEM_WAIT_MAX>0): counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle mem_ready=0. When it reaches MEM_WAIT_MAX: mem_timeout=1, request deasserted, go to FETCH. mem_ready in the same cycle as the limit wins (normal completion).
- With MEM_WAIT_MAX=0 the block waits indefinitely.

Optional Feature:
MIPS_CTRL_JR_EN defined:
- opcode 0 with funct 8 goes from DECODE to JR.
- JR: pc_write=1, pc_source=11, instr_done=1, go to FETCH. No register write.
Undefined:
- funct 8 is treated as ordinary R-type (EXEC/ALUWB). JR state and encoding absent.

Decomposition:
- Package mips_ctrl_pkg: state enum (4-bit), opcode/funct localparams, and encodings for alu_op, pc_source, reg_dst, mem_to_reg and alu_src_b, shared with the ALU control and datapath.
- One sub-module: mips_mem_watchdog (counter + timeout compare).

Test Plan:
- lw (op 35), mem_ready high after 2 wait cycles -> FETCH(3) DECODE MEMADR MEMRD MEMWB; reg_write with mem_to_reg=01; instr_done once.
- add (op 0, funct 32), mem_ready always 1 -> 4 cycles. ALUWB has reg_dst=01, alu_op held 10 in EXEC.
- bne (op 5) -> BRANCH with pc_write_cond=1, branch_ne=1, pc_source=01. beq (op 4) gives branch_ne=0.
- jal (op 3) -> JAL with pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 in the same cycle.
- Opcode 63 -> illegal_op pulse in DECODE, back to FETCH, no instr_done, no write enables.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in MEMWR -> mem_timeout on the 4th wait cycle, mem_write drops, state FETCH. Separately, rst_n low mid-MEMRD -> all outputs 0 immediately, FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode/funct and control-field encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
`ifdef MIPS_CTRL_JR_EN
        S_JAL    = 4'd12,
        S_JR     = 4'd13
`else
        S_JAL    = 4'd12
`endif
    } state_t;

    localparam int OP_RTYPE = 0;
    localparam int OP_J     = 2;
    localparam int OP_JAL   = 3;
    localparam int OP_BEQ   = 4;
    localparam int OP_BNE   = 5;
    localparam int OP_ADDI  = 8;
    localparam int OP_SLTI  = 10;
    localparam int OP_ANDI  = 12;
    localparam int OP_ORI   = 13;
    localparam int OP_LUI   = 15;
    localparam int OP_LW    = 35;
    localparam int OP_SW    = 43;
    localparam int FN_JR    = 8;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OPC   = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_mem_watchdog.sv
// rtl/mips_mem_watchdog.sv - bounded wait counter for memory handshakes; MEM_WAIT_MAX=0 never times out
module mips_mem_watchdog #(
    parameter int MEM_WAIT_MAX = 0,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_leave,
    output logic o_timeout
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    logic [WAIT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || i_leave) begin
            r_cnt <= '0;
        end else if (!i_ready) begin
            r_cnt <= r_cnt + WAIT_CNT_W'(1);
        end
    end

    // Fires on the MEM_WAIT_MAX-th idle cycle; a same-cycle ready completes normally.
    assign o_timeout = (MEM_WAIT_MAX != 0) && i_active && !i_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory handshake and watchdog
// Optional jr support is enabled by defining MIPS_CTRL_JR_EN.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int FN_W         = 6,
    parameter int MEM_WAIT_MAX = 0,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            branch_ne,
    output logic [1:0]      pc_source,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            instr_done,
    output logic            illegal_op,
    output logic            mem_timeout,
    output logic [3:0]      state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       w_wait_state;
    logic       w_leave;
    logic       w_timeout;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_branch_ne;
    logic [1:0] w_pc_source;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_reg_dst;
    logic [1:0] w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_instr_done;
    logic       w_illegal_op;

    logic       w_op_lw;
    logic       w_op_mem;
    logic       w_op_branch;
    logic       w_op_addi;
    logic       w_op_ilogic;

    assign w_op_lw     = (opcode == OP_W'(OP_LW));
    assign w_op_mem    = w_op_lw || (opcode == OP_W'(OP_SW));
    assign w_op_branch = (opcode == OP_W'(OP_BEQ)) || (opcode == OP_W'(OP_BNE));
    assign w_op_addi   = (opcode == OP_W'(OP_ADDI));
    assign w_op_ilogic = (opcode == OP_W'(OP_SLTI)) || (opcode == OP_W'(OP_ANDI))
                      || (opcode == OP_W'(OP_ORI))  || (opcode == OP_W'(OP_LUI));

`ifndef MIPS_CTRL_JR_EN
    logic w_unused_funct;
    assign w_unused_funct = ^funct;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A timeout in FETCH re-enters FETCH, which must still restart the count.
    assign w_leave      = (w_next != r_state) || w_timeout;

    mips_mem_watchdog #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .WAIT_CNT_W   (WAIT_CNT_W)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_wait_state),
        .i_ready   (mem_ready),
        .i_leave   (w_leave),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next          = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_branch_ne     = 1'b0;
        w_pc_source     = PCS_ALU;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = RDST_RT;
        w_mem_to_reg    = M2R_ALU;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = ASB_B;
        w_alu_op        = ALU_ADD;
        w_instr_done    = 1'b0;
        w_illegal_op    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = ASB_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_mem_read = 1'b0;
                    w_next     = S_FETCH;
                end
            end
            S_DECODE: begin
                w_alu_src_b = ASB_IMM_SH2;
                if (opcode == OP_W'(OP_RTYPE)) begin
`ifdef MIPS_CTRL_JR_EN
                    w_next = (funct == FN_W'(FN_JR)) ? S_JR : S_EXEC;
`else
                    w_next = S_EXEC;
`endif
                end else if (w_op_mem) begin
                    w_next = S_MEMADR;
                end else if (w_op_branch) begin
                    w_next = S_BRANCH;
                end else if (w_op_addi || w_op_ilogic) begin
                    w_next = S_IEXEC;
                end else if (opcode == OP_W'(OP_J)) begin
                    w_next = S_JUMP;
                end else if (opcode == OP_W'(OP_JAL)) begin
                    w_next = S_JAL;
                end else begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ASB_IMM;
                w_next      = w_op_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_mem_read = 1'b0;
                    w_next     = S_FETCH;
                end
            end
            S_MEMWB: begin
                w_mem_to_reg = M2R_MDR;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else if (w_timeout) begin
                    w_mem_write = 1'b0;
                    w_next      = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst    = RDST_RD;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCS_ALUOUT;
                w_branch_ne     = (opcode == OP_W'(OP_BNE));
                w_instr_done    = 1'b1;
                w_next          = S_FETCH;
            end
            S_IEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ASB_IMM;
                w_alu_op    = w_op_addi ? ALU_ADD : ALU_OPC;
                w_next      = S_IWB;
            end
            S_IWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCS_JUMP;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so the link value is the pre-edge PC.
                w_pc_write   = 1'b1;
                w_pc_source  = PCS_JUMP;
                w_reg_write  = 1'b1;
                w_reg_dst    = RDST_RA;
                w_mem_to_reg = M2R_PC;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef MIPS_CTRL_JR_EN
            S_JR: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCS_RS;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset forces every control line low immediately, not just at the next edge.
    assign pc_write      = rst_n & w_pc_write;
    assign pc_write_cond = rst_n & w_pc_write_cond;
    assign branch_ne     = rst_n & w_branch_ne;
    assign pc_source     = rst_n ? w_pc_source  : 2'b00;
    assign iord          = rst_n & w_iord;
    assign mem_read      = rst_n & w_mem_read;
    assign mem_write     = rst_n & w_mem_write;
    assign ir_write      = rst_n & w_ir_write;
    assign reg_dst       = rst_n ? w_reg_dst    : 2'b00;
    assign mem_to_reg    = rst_n ? w_mem_to_reg : 2'b00;
    assign reg_write     = rst_n & w_reg_write;
    assign alu_src_a     = rst_n & w_alu_src_a;
    assign alu_src_b     = rst_n ? w_alu_src_b  : 2'b00;
    assign alu_op        = rst_n ? w_alu_op     : 2'b00;
    assign instr_done    = rst_n & w_instr_done;
    assign illegal_op    = rst_n & w_illegal_op;
    assign mem_timeout   = rst_n & w_timeout;
    assign state_o       = r_state;

endmodule
